fixed_decoder: RTL and testbench
================================

# fixed_decoder

Reconstructs 16-bit PCM samples from FLAC fixed-predictor residuals, orders 0–4. It is the inverse of the fixed encoder path and sits in the decode pipeline between the residual (Rice) decoder and the sample output buffer. One residual is accepted per cycle and one sample is produced per accepted residual. Warm-up samples are passed through verbatim.

## Interface
- `SAMPLE_WIDTH`, default 16: width of samples and residuals (two's complement).
- `iClock` in 1: system clock, rising edge.
- `iReset` in 1: asynchronous reset, active-low.
- `iEnable` in 1: global enable; when low, inputs are ignored and state holds.
- `iStart` in 1: single-cycle pulse that begins a new subframe.
- `iOrder` in 3: predictor order, 0–4, sampled when `iStart` is high.
- `iValid` in 1: `iResidual` is valid this cycle.
- `iResidual` in `SAMPLE_WIDTH`: residual, or a warm-up sample during warm-up.
- `oValid` out 1: `oSample` is valid; registered.
- `oSample` out `SAMPLE_WIDTH`: reconstructed sample; registered.
- `oError` out 1: one-cycle pulse when `iOrder` > 4 at `iStart`.

## Operation
- Effective strobes: `start = iEnable & iStart`; `valid = iEnable & iValid`.
- FSM states:
  - IDLE → on start with order ≤ 4: go to WARMUP if order > 0, else DECODE. Latch the order, clear the history `s1..s4`, and clear the warm-up count.
  - IDLE → on start with order > 4: stay in IDLE and pulse `oError`.
  - WARMUP: each valid input outputs the residual verbatim and shifts it into history. After `order` accepted inputs, go to DECODE.
  - DECODE: each valid input outputs `residual + P` and shifts the output into history. The FSM stays in DECODE until the next start.
- `start` is honoured in every state and restarts the block; the history is discarded.
- If `valid` and `start` occur in the same cycle, the residual is the first input of the new block, decoded with the new order and zero history.
- `valid` while in IDLE (no block started): input is ignored and `oValid` stays 0.
- Predictor `P` (`s1` = most recent sample):
  - order 0: 0
  - order 1: `s1`
  - order 2: `2s1 − s2`
  - order 3: `3s1 − 3s2 + s3`
  - order 4: `4s1 − 6s2 + 4s3 − s4`
- Arithmetic is modulo 2^`SAMPLE_WIDTH`. The sum is truncated to `SAMPLE_WIDTH` bits with no saturation. This exactly inverts an encoder that wraps its residuals the same way.
- The history shift uses the truncated output value.

## Timing
- Latency is 1 cycle: `valid` at edge N gives `oValid`=1 and `oSample` at edge N+1.
- `oValid` is high for exactly one cycle per accepted input. Back-to-back input at full rate (1/cycle) is supported.
- `oError` is registered and goes high 1 cycle after the offending start.
- `iEnable` low: no history update, no FSM transition, and `oValid`=0 on the next edge. `oSample` holds its value.
- Reset values (async, on `iReset`=0): FSM=IDLE, order=0, warm-up count=0, `s1..s4`=0, `oValid`=0, `oSample`=0, `oError`=0.
- Reset asserted mid-block aborts the block immediately, with no partial output. After release, the block waits in IDLE for a new start.
- The prediction is combinational from the registered history, so the critical path is the multiply-by-constant adder tree plus the final add. Build constant multiplies from shifts and adds only.

## Structure
- A shared `flac_pkg` holds:
  - `MAX_FIXED_ORDER` = 4
  - the FSM state enum (IDLE / WARMUP / DECODE)
  - the order-code typedef (3 bits)
- The encoder side reuses the same package.
- One natural sub-module is `fixed_predictor`: combinational, inputs `order` and `s1..s4`, output `P`. It is shared with a future encoder refactor.

## Test plan
- Order 1: start, then inputs 20, −10, −17, 3, 12, −8, 2, −5, 4 → outputs 20, 10, −7, −4, 8, 0, 2, −3, 1, each one cycle after its input.
- Order 2: start, then inputs 20, 10, −7, 20, 9 → outputs 20, 10, −7, −4, 8.
- Order 0 and order 4 with a random 1000-sample stream: compare against a software model of the fixed encoder followed by this decoder; reconstruction must be bit-exact, including gaps in `iValid` and cycles with `iEnable` low.
- Wrap: order 1, inputs 32767 then 1 → outputs 32767, −32768.
- Restart and errors:
  - start with order 5 → `oError` pulses, no `oValid` on subsequent inputs.
  - start with order 1 mid-DECODE, with `iValid` in the same cycle and input 7 → output 7 (warm-up restarts).
- Reset: assert `iReset` low mid-stream → `oValid`=0 and `oSample`=0 immediately. After release, inputs are ignored until the next start.

Source files
------------

// File: rtl/flac_pkg.sv
// Shared FLAC fixed-predictor definitions, used by both the encoder and decoder paths.
package flac_pkg;

    localparam int MAX_FIXED_ORDER = 4;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        DECODE
    } fixedState_t;

    typedef logic [2:0] order_t;

endpackage

// File: rtl/fixed_predictor.sv
// Combinational FLAC fixed predictor, orders 0-4; zero latency, no flow control.
// Constant multiplies are shift/add only so the tree stays shallow.
module fixed_predictor
    import flac_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  order_t                  order,
    input  logic [SAMPLE_WIDTH-1:0] s1,
    input  logic [SAMPLE_WIDTH-1:0] s2,
    input  logic [SAMPLE_WIDTH-1:0] s3,
    input  logic [SAMPLE_WIDTH-1:0] s4,
    output logic [SAMPLE_WIDTH-1:0] p
);

    always_comb begin
        p = '0;
        case (order)
            3'd1:    p = s1;
            3'd2:    p = (s1 << 1) - s2;
            3'd3:    p = (s1 << 1) + s1 - (s2 << 1) - s2 + s3;
            3'd4:    p = (s1 << 2) - (s2 << 2) - (s2 << 1) + (s3 << 2) - s4;
            default: p = '0;
        endcase
    end

endmodule

// File: rtl/fixed_decoder.sv
// Rebuilds PCM samples from FLAC fixed-predictor residuals; 1-cycle registered latency.
// No backpressure: one residual accepted per cycle, iEnable low freezes all state.
module fixed_decoder
    import flac_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iEnable,
    input  logic                    iStart,
    input  logic [2:0]              iOrder,
    input  logic                    iValid,
    input  logic [SAMPLE_WIDTH-1:0] iResidual,
    output logic                    oValid,
    output logic [SAMPLE_WIDTH-1:0] oSample,
    output logic                    oError
);

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    fixedState_t state, stateNext, curState;
    order_t      order, orderNext, curOrder;
    logic [2:0]  warmCount, warmCountNext, curCount, countInc;
    sample_t     s1, s2, s3, s4;
    sample_t     s1Next, s2Next, s3Next, s4Next;
    sample_t     c1, c2, c3, c4;
    sample_t     pred, sampleNext;
    logic        validNext, errorNext;
    logic        start, valid, orderOk;

    assign start   = iEnable & iStart;
    assign valid   = iEnable & iValid;
    assign orderOk = (iOrder <= order_t'(MAX_FIXED_ORDER));

    // Predicts from the context the current input will actually see, so a
    // residual arriving with start uses the new order and a cleared history.
    fixed_predictor #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) uPredictor (
        .order(curOrder),
        .s1   (c1),
        .s2   (c2),
        .s3   (c3),
        .s4   (c4),
        .p    (pred)
    );

    always_comb begin
        curState      = state;
        curOrder      = order;
        curCount      = warmCount;
        c1            = s1;
        c2            = s2;
        c3            = s3;
        c4            = s4;
        errorNext     = 1'b0;
        validNext     = 1'b0;
        sampleNext    = oSample;

        if (start) begin
            if (orderOk) begin
                curState = (iOrder == 3'd0) ? DECODE : WARMUP;
                curOrder = iOrder;
                curCount = '0;
                c1       = '0;
                c2       = '0;
                c3       = '0;
                c4       = '0;
            end else begin
                curState  = IDLE;
                errorNext = 1'b1;
            end
        end

        countInc      = curCount + 3'd1;
        stateNext     = curState;
        orderNext     = curOrder;
        warmCountNext = curCount;
        s1Next        = c1;
        s2Next        = c2;
        s3Next        = c3;
        s4Next        = c4;

        if (valid && curState != IDLE) begin
            validNext  = 1'b1;
            sampleNext = (curState == WARMUP) ? iResidual : iResidual + pred;
            s1Next     = sampleNext;
            s2Next     = c1;
            s3Next     = c2;
            s4Next     = c3;
            if (curState == WARMUP) begin
                warmCountNext = countInc;
                if (countInc == curOrder) begin
                    stateNext = DECODE;
                end
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state     <= IDLE;
            order     <= '0;
            warmCount <= '0;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            s4        <= '0;
            oValid    <= 1'b0;
            oSample   <= '0;
            oError    <= 1'b0;
        end else begin
            state     <= stateNext;
            order     <= orderNext;
            warmCount <= warmCountNext;
            s1        <= s1Next;
            s2        <= s2Next;
            s3        <= s3Next;
            s4        <= s4Next;
            oValid    <= validNext;
            oSample   <= sampleNext;
            oError    <= errorNext;
        end
    end

endmodule

// File: tb/tb_fixed_decoder.sv
// Scoreboard bench for fixed_decoder: expected samples queued at drive time, checked on output.
module tb_fixed_decoder;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iEnable = 1'b0;
    logic        iStart = 1'b0;
    logic [2:0]  iOrder = '0;
    logic        iValid = 1'b0;
    logic [15:0] iResidual = '0;
    logic        oValid;
    logic [15:0] oSample;
    logic        oError;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [15:0] s;
        int unsigned c;
    } exp_t;

    exp_t sb[$];
    exp_t monE;

    fixed_decoder #(.SAMPLE_WIDTH(16)) dut (
        .iClock   (iClock),
        .iReset   (iReset),
        .iEnable  (iEnable),
        .iStart   (iStart),
        .iOrder   (iOrder),
        .iValid   (iValid),
        .iResidual(iResidual),
        .oValid   (oValid),
        .oSample  (oSample),
        .oError   (oError)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) cyc <= cyc + 1;

    // Every output beat must match the head of the queue, value and arrival cycle.
    always @(negedge iClock) begin
        if (iReset && oValid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_oValid cycle=%0d got sample=%0d, required no output",
                         cyc, $signed(oSample));
            end else begin
                monE = sb.pop_front();
                if (oSample !== monE.s || cyc !== monE.c) begin
                    failures++;
                    $display("FAIL scoreboard got sample=%0d at cycle %0d, required sample=%0d at cycle %0d",
                             $signed(oSample), cyc, $signed(monE.s), monE.c);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic st, input logic [2:0] ord,
                         input logic vld, input logic [15:0] res,
                         input logic expOut, input logic [15:0] expVal);
        @(negedge iClock);
        iEnable   = en;
        iStart    = st;
        iOrder    = ord;
        iValid    = vld;
        iResidual = res;
        if (expOut) sb.push_back('{expVal, cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    endtask

    function automatic logic [15:0] modelPred(input int ord, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] c,
                                              input logic [15:0] d);
        int sa, sb2, sc, sd, p;
        sa  = int'($signed(a));
        sb2 = int'($signed(b));
        sc  = int'($signed(c));
        sd  = int'($signed(d));
        case (ord)
            1:       p = sa;
            2:       p = 2 * sa - sb2;
            3:       p = 3 * sa - 3 * sb2 + sc;
            4:       p = 4 * sa - 6 * sb2 + 4 * sc - sd;
            default: p = 0;
        endcase
        return p[15:0];
    endfunction

    task automatic test_reset();
        iReset = 1'b0;
        repeat (2) @(negedge iClock);
        checks++;
        if (oValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_oValid got %b, required 0", oValid);
        end
        checks++;
        if (oSample !== 16'd0) begin
            failures++;
            $display("FAIL reset_oSample got %0d, required 0", oSample);
        end
        checks++;
        if (oError !== 1'b0) begin
            failures++;
            $display("FAIL reset_oError got %b, required 0", oError);
        end
        iReset = 1'b1;
        // Valid input before any start must be dropped.
        drive(1'b1, 1'b0, 3'd1, 1'b1, 16'd55, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd1, 1'b1, 16'd56, 1'b0, 16'd0);
        idle(2);
    endtask

    task automatic test_order1();
        int inp[9] = '{20, -10, -17, 3, 12, -8, 2, -5, 4};
        int outp[9] = '{20, 10, -7, -4, 8, 0, 2, -3, 1};
        drive(1'b1, 1'b1, 3'd1, 1'b0, 16'd0, 1'b0, 16'd0);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 3'd0, 1'b1, 16'(inp[i]), 1'b1, 16'(outp[i]));
        idle(2);
    endtask

    task automatic test_order2();
        int inp[5] = '{20, 10, -7, 20, 9};
        int outp[5] = '{20, 10, -7, -4, 8};
        drive(1'b1, 1'b1, 3'd2, 1'b0, 16'd0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 3'd0, 1'b1, 16'(inp[i]), 1'b1, 16'(outp[i]));
        idle(2);
    endtask

    // Encoder model feeds residuals; the decoder must return the original samples.
    task automatic test_random(input int ord);
        logic [15:0] h1, h2, h3, h4, x, r;
        h1 = '0; h2 = '0; h3 = '0; h4 = '0;
        drive(1'b1, 1'b1, 3'(ord), 1'b0, 16'd0, 1'b0, 16'd0);
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            r = (i < ord) ? x : x - modelPred(ord, h1, h2, h3, h4);
            if ($urandom_range(0, 4) == 0) drive(1'b1, 1'b0, 3'd0, 1'b0, 16'($urandom), 1'b0, 16'd0);
            if ($urandom_range(0, 7) == 0) drive(1'b0, 1'b1, 3'd1, 1'b1, 16'($urandom), 1'b0, 16'd0);
            drive(1'b1, 1'b0, 3'd0, 1'b1, r, 1'b1, x);
            h4 = h3; h3 = h2; h2 = h1; h1 = x;
        end
        idle(2);
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 3'd1, 1'b0, 16'd0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd32767, 1'b1, 16'h7fff);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd1, 1'b1, 16'h8000);
        drive(1'b0, 1'b0, 3'd0, 1'b1, 16'h1234, 1'b0, 16'd0);
        @(negedge iClock);
        checks++;
        if (oValid !== 1'b0) begin
            failures++;
            $display("FAIL enable_low_oValid got %b, required 0", oValid);
        end
        checks++;
        if (oSample !== 16'h8000) begin
            failures++;
            $display("FAIL enable_low_hold got %h, required 8000", oSample);
        end
        iEnable = 1'b1;
        iValid  = 1'b0;
    endtask

    task automatic test_error();
        drive(1'b1, 1'b1, 3'd5, 1'b0, 16'd0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd99, 1'b0, 16'd0);
        checks++;
        if (oError !== 1'b1) begin
            failures++;
            $display("FAIL error_pulse got %b, required 1", oError);
        end
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd100, 1'b0, 16'd0);
        checks++;
        if (oError !== 1'b0) begin
            failures++;
            $display("FAIL error_one_cycle got %b, required 0", oError);
        end
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd101, 1'b0, 16'd0);
        idle(2);
    endtask

    task automatic test_restart();
        drive(1'b1, 1'b1, 3'd1, 1'b0, 16'd0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd5, 1'b1, 16'd5);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd4, 1'b1, 16'd9);
        drive(1'b1, 1'b1, 3'd1, 1'b1, 16'd7, 1'b1, 16'd7);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd3, 1'b1, 16'd10);
        idle(2);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 3'd2, 1'b0, 16'd0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd100, 1'b1, 16'd100);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd50, 1'b1, 16'd50);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd10, 1'b0, 16'd0);
        @(posedge iClock);
        #1;
        checks++;
        if (oValid !== 1'b1 || oSample !== 16'd10) begin
            failures++;
            $display("FAIL pre_reset_output got valid=%b sample=%0d, required valid=1 sample=10",
                     oValid, oSample);
        end
        iReset = 1'b0;
        #1;
        checks++;
        if (oValid !== 1'b0 || oSample !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%b sample=%0d, required valid=0 sample=0",
                     oValid, oSample);
        end
        iValid = 1'b0;
        @(negedge iClock);
        iReset = 1'b1;
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd11, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd12, 1'b0, 16'd0);
        drive(1'b1, 1'b1, 3'd0, 1'b0, 16'd0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 3'd0, 1'b1, 16'd42, 1'b1, 16'd42);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_order1();
        test_order2();
        test_random(0);
        test_random(4);
        test_wrap();
        test_error();
        test_restart();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_outputs got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
